prf_freelist: RTL
=================

PRF_FREELIST -- requirements
Module: prf_freelist

Interface
REQ-001 Parameter AW, default 6, physical register index width; the buffer holds 2^AW entries.
REQ-002 Parameter NUM_ARCH, default 32, architectural register count; must satisfy 1 <= NUM_ARCH < 2^AW.
REQ-003 Parameter NUM_ALLOC, default 2, allocation slots per cycle.
REQ-004 Parameter NUM_FREE, default 2, free/commit slots per cycle.
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 alloc_req  in  NUM_ALLOC  per-slot rename request; any bit pattern is legal.
REQ-008 alloc_ready  out  1  free count >= NUM_ALLOC and flush low.
REQ-009 alloc_prd  out  AW*NUM_ALLOC  granted physical register per slot, combinational; slot i is bits [i*AW +: AW].
REQ-010 free_we  in  NUM_FREE  per-slot return of a retired old mapping.
REQ-011 free_prd  in  AW*NUM_FREE  register returned per slot.
REQ-012 commit_alloc  in  NUM_FREE  per-slot flag: a retiring instruction had allocated a register.
REQ-013 flush  in  1  misprediction/exception recovery; discards speculative allocations.
REQ-014 free_cnt  out  AW+1  registers currently free for speculative allocation.

Function
REQ-015 The block SHALL keep a circular buffer of 2^AW AW-bit entries and three AW-bit pointers: spec_head, arch_head and tail, each wrapping modulo 2^AW.
REQ-016 free_cnt SHALL equal (tail - spec_head) mod 2^AW, zero-extended; the buffer is never full because at most 2^AW - NUM_ARCH registers are free.
REQ-017 An allocation fires when alloc_ready is high and at least one alloc_req bit is set; n_alloc = popcount(alloc_req).
REQ-018 Allocation SHALL be compacted: set bit i receives entry buf[spec_head + popcount(alloc_req[i-1:0])]; alloc_prd for an unrequested slot is don't-care.
REQ-019 On fire, spec_head SHALL advance by n_alloc at the clock edge; the returned value is valid in the same cycle as the request (zero latency).
REQ-020 When alloc_ready is low, alloc_req SHALL have no effect; no partial grant is made.
REQ-021 Frees: slot j with free_we[j] high SHALL write free_prd[j] to buf[tail + popcount(free_we[j-1:0])]; tail advances by popcount(free_we).
REQ-022 Commits: arch_head SHALL advance by popcount(commit_alloc) every cycle, flush or not.
REQ-023 On flush, spec_head SHALL load arch_head + popcount(commit_alloc) (same-cycle commits included); any same-cycle allocation is suppressed.
REQ-024 Frees in a flush cycle SHALL be accepted normally.
REQ-025 Simultaneous alloc and free SHALL both take effect; a register freed this cycle is not allocatable until the next cycle.
REQ-026 The block performs no duplicate or range checks on free_prd; the producer guarantees validity.

Reset
REQ-027 While RST is low: buf[k] = NUM_ARCH + k for k < 2^AW - NUM_ARCH, other entries 0; spec_head = arch_head = 0; tail = 2^AW - NUM_ARCH.
REQ-028 Immediately after reset, free_cnt = 2^AW - NUM_ARCH and alloc_ready = 1 when that value is >= NUM_ALLOC.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight state and restore REQ-027 values regardless of flush, alloc or free inputs.

Verification (AW=6, NUM_ARCH=32, NUM_ALLOC=2, NUM_FREE=2)
REQ-030 Reset, alloc_req=11 for two cycles -> alloc_prd slot0/slot1 = 32/33, then 34/35; free_cnt 32->30->28.
REQ-031 Reset, alloc_req=10 -> slot1 gets 32; the next alloc_req=01 -> slot0 gets 33.
REQ-032 Drain with alloc_req=11 for 16 cycles -> free_cnt=0, alloc_ready=0; further requests leave spec_head unchanged; one free of reg 5 -> free_cnt=1, alloc_ready still 0.
REQ-033 Allocate 32,33,34; commit_alloc=01 together with flush -> spec_head=1, next alloc_req=01 gets 33, free_cnt=31.
REQ-034 Tail wrap: after draining, free regs 40,41 repeatedly -> writes land at indices 32..63 then 0,1; allocations return the freed values in FIFO order.
REQ-035 Assert RST mid-stream with flush and free_we active -> free_cnt=32, the next alloc_req=11 grants 32/33.

Source files
------------

// File: rtl/prf_freelist.sv
// Physical register free list: circular buffer with speculative/architectural heads and a tail.
// Allocation is zero-latency and compacted; flush rewinds the speculative head to the committed one.
module prf_freelist #(
  parameter int AW        = 6,
  parameter int NUM_ARCH  = 32,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_FREE  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_ALLOC-1:0]    alloc_req_i,
  output logic                    alloc_ready_o,
  output logic [AW*NUM_ALLOC-1:0] alloc_prd_o,
  input  logic [NUM_FREE-1:0]     free_we_i,
  input  logic [AW*NUM_FREE-1:0]  free_prd_i,
  input  logic [NUM_FREE-1:0]     commit_alloc_i,
  input  logic                    flush_i,
  output logic [AW:0]             free_cnt_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ALLOC_MIN = (AW+1)'(NUM_ALLOC);

  typedef logic [AW-1:0] ptr_t;

  ptr_t buf_q [DEPTH];
  ptr_t spec_head_q, spec_head_d;
  ptr_t arch_head_q, arch_head_d;
  ptr_t tail_q,      tail_d;

  ptr_t n_alloc;
  ptr_t n_commit;
  ptr_t n_free;
  ptr_t free_pos [NUM_FREE];
  logic alloc_fire;

  // The buffer never fills, so the pointer difference is the exact free count.
  assign free_cnt_o    = {1'b0, ptr_t'(tail_q - spec_head_q)};
  assign alloc_ready_o = (free_cnt_o >= ALLOC_MIN) && !flush_i;
  assign alloc_fire    = alloc_ready_o && (|alloc_req_i);

  // NOTE: blocking '=' is correct inside always_comb; the running count must be
  // visible to the next loop iteration within the same evaluation.
  always_comb begin
    n_alloc     = '0;
    alloc_prd_o = '0;
    for (int i = 0; i < NUM_ALLOC; i++) begin
      alloc_prd_o[i*AW +: AW] = buf_q[ptr_t'(spec_head_q + n_alloc)];
      if (alloc_req_i[i]) n_alloc = n_alloc + ptr_t'(1);
    end
  end

  always_comb begin
    n_free = '0;
    for (int j = 0; j < NUM_FREE; j++) begin
      free_pos[j] = ptr_t'(tail_q + n_free);
      if (free_we_i[j]) n_free = n_free + ptr_t'(1);
    end
  end

  always_comb begin
    n_commit = '0;
    for (int j = 0; j < NUM_FREE; j++) begin
      if (commit_alloc_i[j]) n_commit = n_commit + ptr_t'(1);
    end
  end

  // NOTE: every next-state signal gets its default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    arch_head_d = ptr_t'(arch_head_q + n_commit);
    tail_d      = ptr_t'(tail_q + n_free);
    spec_head_d = spec_head_q;
    if (flush_i) begin
      spec_head_d = arch_head_d;
    end else if (alloc_fire) begin
      spec_head_d = ptr_t'(spec_head_q + n_alloc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= ptr_t'(DEPTH - NUM_ARCH);
    end else begin
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  // NOTE: this memory is reset on purpose -- the initial free registers live in
  // it, so it cannot be left to power-up contents like an ordinary RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        buf_q[k] <= (k < DEPTH - NUM_ARCH) ? ptr_t'(NUM_ARCH + k) : '0;
      end
    end else begin
      for (int j = 0; j < NUM_FREE; j++) begin
        if (free_we_i[j]) buf_q[free_pos[j]] <= free_prd_i[j*AW +: AW];
      end
    end
  end

endmodule
